cr16_control_fsm: RTL and testbench

// Multi-cycle sequencer for the CR16 core: fetch, decode, execute, memory, writeback, PC update.

---
 rtl/cr16_control_fsm.sv | 243 ++++++++++++++++++++++++
 tb/tb_cr16_control_fsm.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/cr16_control_fsm.sv
// CR16 multi-cycle control sequencer: fetch, decode, execute, memory, writeback, PC update.
// Drives the memory handshake, IR load, register-file/flag write enables and the pc block controls.
module cr16_control_fsm #(
    parameter int P_ADDRESS_WIDTH = 16
) (
    input  logic                       i_clk,
    input  logic                       i_reset,
    input  logic                       i_enable,
    input  logic [15:0]                i_instruction,
    input  logic [4:0]                 i_flags,
    input  logic [15:0]                i_rtarget,
    input  logic                       i_mem_ready,
    output logic [2:0]                 o_state,
    output logic                       o_mem_req,
    output logic                       o_mem_we,
    output logic                       o_mem_addr_sel,
    output logic                       o_ir_load,
    output logic                       o_rf_we,
    output logic [1:0]                 o_rf_wd_sel,
    output logic                       o_flags_we,
    output logic                       o_pc_enable,
    output logic [P_ADDRESS_WIDTH-1:0] o_pc_address,
    output logic                       o_pc_address_select,
    output logic                       o_pc_address_select_increment,
    output logic                       o_pc_address_select_displace
);

    localparam logic [2:0] S_FETCH     = 3'd0;
    localparam logic [2:0] S_DECODE    = 3'd1;
    localparam logic [2:0] S_EXECUTE   = 3'd2;
    localparam logic [2:0] S_MEM       = 3'd3;
    localparam logic [2:0] S_WRITEBACK = 3'd4;
    localparam logic [2:0] S_PC_UPDATE = 3'd5;

    logic [2:0]                 r_state;
    logic [2:0]                 w_next_state;
    logic                       r_fetch_pending;
    logic                       r_pc_enable;
    logic                       r_pc_select;
    logic                       r_pc_displace;
    logic [P_ADDRESS_WIDTH-1:0] r_pc_address;
    logic                       r_exec_rf_we;
    logic                       r_exec_flags_we;
    logic                       r_exec_link;
    logic                       r_is_load;
    logic                       r_is_store;

    logic [3:0] w_op;
    logic [3:0] w_ext;
    logic [3:0] w_cond;
    logic [7:0] w_disp;
    logic       w_fetch_req;
    logic       w_cond_met;
    logic       w_is_load;
    logic       w_is_store;
    logic       w_is_jal;
    logic       w_is_jcond;
    logic       w_is_bcond;
    logic       w_rf_we;
    logic       w_flags_we;

    assign w_op   = i_instruction[15:12];
    assign w_cond = i_instruction[11:8];
    assign w_ext  = i_instruction[7:4];
    assign w_disp = i_instruction[7:0];

    // A fetch request, once issued, stays up until memory answers even if i_enable drops.
    assign w_fetch_req = i_enable | r_fetch_pending;

    // Flags are {C,L,F,Z,N}.
    always_comb begin
        unique case (w_cond)
            4'h0:    w_cond_met = i_flags[1];
            4'h1:    w_cond_met = !i_flags[1];
            4'h2:    w_cond_met = i_flags[4];
            4'h3:    w_cond_met = !i_flags[4];
            4'h4:    w_cond_met = i_flags[3];
            4'h5:    w_cond_met = !i_flags[3];
            4'h6:    w_cond_met = i_flags[0];
            4'h7:    w_cond_met = !i_flags[0];
            4'h8:    w_cond_met = i_flags[2];
            4'h9:    w_cond_met = !i_flags[2];
            4'hA:    w_cond_met = !i_flags[3] && !i_flags[1];
            4'hB:    w_cond_met = i_flags[3] || i_flags[1];
            4'hC:    w_cond_met = !i_flags[0] && !i_flags[1];
            4'hD:    w_cond_met = i_flags[0] || i_flags[1];
            4'hE:    w_cond_met = 1'b1;
            default: w_cond_met = 1'b0;
        endcase
    end

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        w_is_load  = 1'b0;
        w_is_store = 1'b0;
        w_is_jal   = 1'b0;
        w_is_jcond = 1'b0;
        w_is_bcond = 1'b0;
        w_rf_we    = 1'b0;
        w_flags_we = 1'b0;
        case (w_op)
            4'h0: begin
                case (w_ext)
                    4'h1, 4'h2, 4'h3, 4'h6, 4'h7, 4'hA, 4'hD, 4'hE: w_rf_we = 1'b1;
                    4'h5, 4'h9: begin
                        w_rf_we    = 1'b1;
                        w_flags_we = 1'b1;
                    end
                    4'hB:    w_flags_we = 1'b1;
                    default: ;
                endcase
            end
            4'h4: begin
                case (w_ext)
                    4'h0: w_is_load  = 1'b1;
                    4'h4: w_is_store = 1'b1;
                    4'h8: begin
                        w_is_jal = 1'b1;
                        w_rf_we  = 1'b1;
                    end
                    4'hC:    w_is_jcond = 1'b1;
                    default: ;
                endcase
            end
            4'h5, 4'h9: begin
                w_rf_we    = 1'b1;
                w_flags_we = 1'b1;
            end
            4'hB:    w_flags_we = 1'b1;
            4'hC:    w_is_bcond = 1'b1;
            default: w_rf_we = 1'b1;
        endcase
    end

    always_comb begin
        w_next_state = S_FETCH;
        case (r_state)
            S_FETCH:     w_next_state = (w_fetch_req && i_mem_ready) ? S_DECODE : S_FETCH;
            S_DECODE:    w_next_state = (w_is_load || w_is_store) ? S_MEM : S_EXECUTE;
            S_EXECUTE:   w_next_state = S_PC_UPDATE;
            S_MEM: begin
                if (!i_mem_ready)   w_next_state = S_MEM;
                else if (r_is_load) w_next_state = S_WRITEBACK;
                else                w_next_state = S_PC_UPDATE;
            end
            S_WRITEBACK: w_next_state = S_PC_UPDATE;
            default:     w_next_state = S_FETCH;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments only, so every flop samples pre-edge values.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state         <= S_FETCH;
            r_fetch_pending <= 1'b0;
            r_pc_enable     <= 1'b0;
            r_pc_select     <= 1'b0;
            r_pc_displace   <= 1'b0;
            r_pc_address    <= '0;
            r_exec_rf_we    <= 1'b0;
            r_exec_flags_we <= 1'b0;
            r_exec_link     <= 1'b0;
            r_is_load       <= 1'b0;
            r_is_store      <= 1'b0;
        end else begin
            r_state         <= w_next_state;
            r_fetch_pending <= (r_state == S_FETCH) && w_fetch_req && !i_mem_ready;
            r_pc_enable     <= (w_next_state == S_PC_UPDATE);
            if (r_state == S_DECODE) begin
                r_exec_rf_we    <= w_rf_we;
                r_exec_flags_we <= w_flags_we;
                r_exec_link     <= w_is_jal;
                r_is_load       <= w_is_load;
                r_is_store      <= w_is_store;
                // PC controls settle here, well ahead of the PC_UPDATE strobe.
                if (w_is_bcond && w_cond_met) begin
                    r_pc_select   <= 1'b1;
                    r_pc_displace <= 1'b1;
                    r_pc_address  <= {{(P_ADDRESS_WIDTH-8){w_disp[7]}}, w_disp};
                end else if (w_is_jal || (w_is_jcond && w_cond_met)) begin
                    r_pc_select   <= 1'b1;
                    r_pc_displace <= 1'b0;
                    r_pc_address  <= P_ADDRESS_WIDTH'(i_rtarget);
                end else begin
                    r_pc_select   <= 1'b0;
                    r_pc_displace <= 1'b0;
                    r_pc_address  <= '0;
                end
            end else if (r_state == S_PC_UPDATE) begin
                r_exec_rf_we    <= 1'b0;
                r_exec_flags_we <= 1'b0;
                r_exec_link     <= 1'b0;
                r_is_load       <= 1'b0;
                r_is_store      <= 1'b0;
                r_pc_select     <= 1'b0;
                r_pc_displace   <= 1'b0;
                r_pc_address    <= '0;
            end
        end
    end

    // Reset also silences the state-decoded strobes during the reset cycle itself.
    always_comb begin
        o_mem_req      = 1'b0;
        o_mem_we       = 1'b0;
        o_mem_addr_sel = 1'b0;
        o_ir_load      = 1'b0;
        o_rf_we        = 1'b0;
        o_rf_wd_sel    = 2'd0;
        o_flags_we     = 1'b0;
        if (!i_reset) begin
            case (r_state)
                S_FETCH: begin
                    o_mem_req = w_fetch_req;
                    o_ir_load = w_fetch_req && i_mem_ready;
                end
                S_EXECUTE: begin
                    o_rf_we     = r_exec_rf_we;
                    o_flags_we  = r_exec_flags_we;
                    o_rf_wd_sel = r_exec_link ? 2'd2 : 2'd0;
                end
                S_MEM: begin
                    o_mem_req      = 1'b1;
                    o_mem_addr_sel = 1'b1;
                    o_mem_we       = r_is_store;
                end
                S_WRITEBACK: begin
                    o_rf_we     = 1'b1;
                    o_rf_wd_sel = 2'd1;
                end
                default: ;
            endcase
        end
    end

    assign o_state                       = r_state;
    assign o_pc_enable                   = r_pc_enable;
    assign o_pc_address                  = r_pc_address;
    assign o_pc_address_select           = r_pc_select;
    assign o_pc_address_select_displace  = r_pc_displace;
    assign o_pc_address_select_increment = 1'b0;

endmodule

// File: tb/tb_cr16_control_fsm.sv
// Directed bench for cr16_control_fsm: table of single-instruction vectors plus
// hand-written sequences for reset, enable gating and memory wait states.
module tb_cr16_control_fsm;

    logic        i_clk = 1'b0;
    logic        i_reset;
    logic        i_enable;
    logic [15:0] i_instruction;
    logic [4:0]  i_flags;
    logic [15:0] i_rtarget;
    logic        i_mem_ready;
    logic [2:0]  o_state;
    logic        o_mem_req;
    logic        o_mem_we;
    logic        o_mem_addr_sel;
    logic        o_ir_load;
    logic        o_rf_we;
    logic [1:0]  o_rf_wd_sel;
    logic        o_flags_we;
    logic        o_pc_enable;
    logic [15:0] o_pc_address;
    logic        o_pc_address_select;
    logic        o_pc_address_select_increment;
    logic        o_pc_address_select_displace;

    int n_tests = 0;
    int n_fail  = 0;

    cr16_control_fsm #(.P_ADDRESS_WIDTH(16)) dut (
        .i_clk                         (i_clk),
        .i_reset                       (i_reset),
        .i_enable                      (i_enable),
        .i_instruction                 (i_instruction),
        .i_flags                       (i_flags),
        .i_rtarget                     (i_rtarget),
        .i_mem_ready                   (i_mem_ready),
        .o_state                       (o_state),
        .o_mem_req                     (o_mem_req),
        .o_mem_we                      (o_mem_we),
        .o_mem_addr_sel                (o_mem_addr_sel),
        .o_ir_load                     (o_ir_load),
        .o_rf_we                       (o_rf_we),
        .o_rf_wd_sel                   (o_rf_wd_sel),
        .o_flags_we                    (o_flags_we),
        .o_pc_enable                   (o_pc_enable),
        .o_pc_address                  (o_pc_address),
        .o_pc_address_select           (o_pc_address_select),
        .o_pc_address_select_increment (o_pc_address_select_increment),
        .o_pc_address_select_displace  (o_pc_address_select_displace)
    );

    always #5 i_clk = ~i_clk;

    typedef struct {
        logic [15:0] instr;
        logic [4:0]  flags;
        logic [15:0] rtarget;
        int          cycles;
        logic        rf_we;
        logic        flags_we;
        logic [1:0]  wd_sel;
        logic        mem_we;
        logic        sel;
        logic        disp;
        logic [15:0] addr;
    } vec_t;

    vec_t vecs[18];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic next_cycle();
        @(posedge i_clk);
        #1;
    endtask

    // Runs one instruction with zero-wait memory from FETCH until the PC strobe, then idles one cycle.
    task automatic run_instr(input int idx, input vec_t v);
        int          cyc_pe   = 0;
        logic        rf_seen  = 1'b0;
        logic        fl_seen  = 1'b0;
        logic        we_seen  = 1'b0;
        logic [1:0]  wd_seen  = 2'd0;
        logic        sel_pe   = 1'b0;
        logic        disp_pe  = 1'b0;
        logic        inc_pe   = 1'b0;
        logic [15:0] addr_pe  = 16'h0;
        logic        sel_pre  = 1'b0;
        logic        disp_pre = 1'b0;
        logic [15:0] addr_pre = 16'h0;
        i_instruction = v.instr;
        i_flags       = v.flags;
        i_rtarget     = v.rtarget;
        i_mem_ready   = 1'b1;
        i_enable      = 1'b1;
        for (int c = 1; c <= 20 && cyc_pe == 0; c++) begin
            @(negedge i_clk);
            if (o_rf_we) begin
                rf_seen = 1'b1;
                wd_seen = wd_seen | o_rf_wd_sel;
            end
            if (o_flags_we) fl_seen = 1'b1;
            if (o_mem_req && o_mem_we) we_seen = 1'b1;
            if (o_pc_enable) begin
                cyc_pe  = c;
                sel_pe  = o_pc_address_select;
                disp_pe = o_pc_address_select_displace;
                inc_pe  = o_pc_address_select_increment;
                addr_pe = o_pc_address;
            end else begin
                sel_pre  = o_pc_address_select;
                disp_pre = o_pc_address_select_displace;
                addr_pre = o_pc_address;
            end
            next_cycle();
        end
        i_enable = 1'b0;
        check($sformatf("v%0d_cycles", idx), cyc_pe, v.cycles);
        check($sformatf("v%0d_rf_we", idx), rf_seen, v.rf_we);
        check($sformatf("v%0d_flags_we", idx), fl_seen, v.flags_we);
        check($sformatf("v%0d_wd_sel", idx), wd_seen, v.wd_sel);
        check($sformatf("v%0d_mem_we", idx), we_seen, v.mem_we);
        check($sformatf("v%0d_select", idx), sel_pe, v.sel);
        check($sformatf("v%0d_displace", idx), disp_pe, v.disp);
        check($sformatf("v%0d_address", idx), addr_pe, v.addr);
        check($sformatf("v%0d_increment", idx), inc_pe, 1'b0);
        check($sformatf("v%0d_setup", idx), {sel_pre, disp_pre, addr_pre}, {v.sel, v.disp, v.addr});
        @(negedge i_clk);
        check($sformatf("v%0d_pe_drop", idx), o_pc_enable, 1'b0);
        check($sformatf("v%0d_back_fetch", idx), o_state, 3'd0);
        check($sformatf("v%0d_sel_clear", idx), o_pc_address_select, 1'b0);
        next_cycle();
    endtask

    task automatic check_cycle(input string name, input logic [2:0] st, input logic req,
                               input logic rf_we, input logic pe);
        @(negedge i_clk);
        check({name, "_state"}, o_state, st);
        check({name, "_req"}, o_mem_req, req);
        check({name, "_rf_we"}, o_rf_we, rf_we);
        check({name, "_pe"}, o_pc_enable, pe);
    endtask

    initial begin
        //            instr     flags     rtarget  cyc rf fl wd  mwe sel disp addr
        vecs[0]  = '{16'h0153, 5'b00000, 16'h0000, 4, 1, 1, 2'd0, 0, 0, 0, 16'h0000}; // ADD
        vecs[1]  = '{16'hC0FE, 5'b00010, 16'h0000, 4, 0, 0, 2'd0, 0, 1, 1, 16'hFFFE}; // BEQ taken
        vecs[2]  = '{16'hC0FE, 5'b00000, 16'h0000, 4, 0, 0, 2'd0, 0, 0, 0, 16'h0000}; // BEQ not taken
        vecs[3]  = '{16'h4E83, 5'b00000, 16'h0040, 4, 1, 0, 2'd2, 0, 1, 0, 16'h0040}; // JAL
        vecs[4]  = '{16'h01B2, 5'b00000, 16'h0000, 4, 0, 1, 2'd0, 0, 0, 0, 16'h0000}; // CMP
        vecs[5]  = '{16'h5105, 5'b00000, 16'h0000, 4, 1, 1, 2'd0, 0, 0, 0, 16'h0000}; // ADDI
        vecs[6]  = '{16'hD1FF, 5'b00000, 16'h0000, 4, 1, 0, 2'd0, 0, 0, 0, 16'h0000}; // MOVI
        vecs[7]  = '{16'h41C3, 5'b00000, 16'h1234, 4, 0, 0, 2'd0, 0, 1, 0, 16'h1234}; // JNE taken
        vecs[8]  = '{16'h41C3, 5'b00010, 16'h1234, 4, 0, 0, 2'd0, 0, 0, 0, 16'h0000}; // JNE not taken
        vecs[9]  = '{16'hC605, 5'b00001, 16'h0000, 4, 0, 0, 2'd0, 0, 1, 1, 16'h0005}; // BGT N=1
        vecs[10] = '{16'hCE10, 5'b11111, 16'h0000, 4, 0, 0, 2'd0, 0, 1, 1, 16'h0010}; // BUC
        vecs[11] = '{16'hCF10, 5'b11111, 16'h0000, 4, 0, 0, 2'd0, 0, 0, 0, 16'h0000}; // never
        vecs[12] = '{16'hCA80, 5'b00000, 16'h0000, 4, 0, 0, 2'd0, 0, 1, 1, 16'hFF80}; // BLO taken
        vecs[13] = '{16'hCB80, 5'b00000, 16'h0000, 4, 0, 0, 2'd0, 0, 0, 0, 16'h0000}; // BHS not taken
        vecs[14] = '{16'h4142, 5'b00000, 16'h0000, 4, 0, 0, 2'd0, 1, 0, 0, 16'h0000}; // STOR
        vecs[15] = '{16'h4102, 5'b00000, 16'h0000, 5, 1, 0, 2'd1, 0, 0, 0, 16'h0000}; // LOAD
        vecs[16] = '{16'h0000, 5'b00000, 16'h0000, 4, 0, 0, 2'd0, 0, 0, 0, 16'h0000}; // undefined
        vecs[17] = '{16'h8142, 5'b00000, 16'h0000, 4, 1, 0, 2'd0, 0, 0, 0, 16'h0000}; // shift

        i_reset       = 1'b1;
        i_enable      = 1'b0;
        i_instruction = 16'h0;
        i_flags       = 5'h0;
        i_rtarget     = 16'h0;
        i_mem_ready   = 1'b0;
        repeat (2) next_cycle();
        @(negedge i_clk);
        check("rst_state", o_state, 3'd0);
        check("rst_strobes", {o_mem_req, o_mem_we, o_mem_addr_sel, o_ir_load, o_rf_we, o_flags_we}, 6'h0);
        check("rst_pc", {o_pc_enable, o_pc_address_select, o_pc_address_select_displace, o_pc_address}, 19'h0);
        next_cycle();
        i_reset = 1'b0;

        // Enable low: FETCH idles without a request, then requests as soon as it rises.
        i_mem_ready = 1'b1;
        for (int c = 0; c < 3; c++) check_cycle($sformatf("idle%0d", c), 3'd0, 1'b0, 1'b0, 1'b0);
        next_cycle();

        for (int i = 0; i < 18; i++) run_instr(i, vecs[i]);

        // LOAD with three wait cycles in MEM.
        i_instruction = 16'h4102;
        i_enable      = 1'b1;
        i_mem_ready   = 1'b1;
        @(negedge i_clk);
        check("ldw_fetch_irload", o_ir_load, 1'b1);
        next_cycle();
        i_enable    = 1'b0;
        i_mem_ready = 1'b0;
        check_cycle("ldw_decode", 3'd1, 1'b0, 1'b0, 1'b0);
        for (int c = 0; c < 4; c++) begin
            next_cycle();
            if (c == 3) i_mem_ready = 1'b1;
            check_cycle($sformatf("ldw_mem%0d", c), 3'd3, 1'b1, 1'b0, 1'b0);
            check($sformatf("ldw_mem%0d_sel_we", c), {o_mem_addr_sel, o_mem_we}, 2'b10);
        end
        next_cycle();
        check_cycle("ldw_wb", 3'd4, 1'b0, 1'b1, 1'b0);
        check("ldw_wb_wd", o_rf_wd_sel, 2'd1);
        next_cycle();
        check_cycle("ldw_pcu", 3'd5, 1'b0, 1'b0, 1'b1);
        next_cycle();
        check_cycle("ldw_done", 3'd0, 1'b0, 1'b0, 1'b0);
        next_cycle();

        // Reset while a load sits in MEM with memory answering in the same cycle.
        i_enable    = 1'b1;
        i_mem_ready = 1'b1;
        next_cycle();
        next_cycle();
        i_enable = 1'b0;
        i_reset  = 1'b1;
        @(negedge i_clk);
        check("rstmem_rf_we", o_rf_we, 1'b0);
        check("rstmem_pe", o_pc_enable, 1'b0);
        next_cycle();
        i_reset = 1'b0;
        for (int c = 0; c < 3; c++) begin
            check_cycle($sformatf("rstmem_after%0d", c), 3'd0, 1'b0, 1'b0, 1'b0);
            next_cycle();
        end

        // An issued fetch completes even after enable drops.
        i_instruction = 16'h0153;
        i_enable      = 1'b1;
        i_mem_ready   = 1'b0;
        check_cycle("fw_req", 3'd0, 1'b1, 1'b0, 1'b0);
        next_cycle();
        i_enable = 1'b0;
        check_cycle("fw_hold", 3'd0, 1'b1, 1'b0, 1'b0);
        check("fw_hold_addr", o_mem_addr_sel, 1'b0);
        next_cycle();
        i_mem_ready = 1'b1;
        check_cycle("fw_ready", 3'd0, 1'b1, 1'b0, 1'b0);
        check("fw_irload", o_ir_load, 1'b1);
        next_cycle();
        check_cycle("fw_decode", 3'd1, 1'b0, 1'b0, 1'b0);
        next_cycle();
        check_cycle("fw_exec", 3'd2, 1'b0, 1'b1, 1'b0);
        check("fw_exec_flags", o_flags_we, 1'b1);
        next_cycle();
        check_cycle("fw_pcu", 3'd5, 1'b0, 1'b0, 1'b1);
        next_cycle();
        check_cycle("fw_idle", 3'd0, 1'b0, 1'b0, 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
